pattern_tx: RTL and testbench

Serial pattern transmitter: the transmit end of the serial pattern link consumed by the pattern detector.
- Accepts a parallel WIDTH-bit pattern via a load/ready handshake.
- Shifts it out MSB-first on serial_out, one bit per clk, qualified by serial_valid.
- Optionally repeats the pattern, with an idle gap between repetitions.
- Drives detector stimulus on-chip and in benches.

---
 rtl/pattern_pkg.sv | 14 +
 rtl/pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_pattern_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the serial pattern link (transmitter side).
package pattern_pkg;

  // Default pattern width, common to the transmitter and the pattern detector.
  localparam int PATT_W = 5;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit pattern on load&&ready,
// shifts it out MSB-first with serial_valid, optionally repeating it with
// GAP_CYCLES idle cycles between repetitions, and pulses done afterwards.
//
// Handshake: a transfer starts on a rising edge where load=1 and ready=1;
// patternIn and repeat_n are sampled on that edge only. load while ready=0
// is dropped (no queuing). ready rises together with done, so a load held
// on the done cycle is accepted and its first bit follows immediately.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH      = PATT_W,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] patternIn,
  input  logic [RPT_W-1:0] repeat_n,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output tx_state_t        o_dbg_state
);

  localparam int              BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BC_TOP   = BC_W'(WIDTH - 1);
  localparam int              GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = HAS_GAP ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;   // bits still to be presented, MSB next
  logic [WIDTH-1:0] r_pat, w_pat_nxt;       // saved copy for repetitions
  logic [BC_W-1:0]  r_bit_cnt, w_bit_cnt_nxt; // index of the bit on serial_out
  logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt_nxt; // repetitions still owed
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic             r_ready, r_serial_out, r_serial_valid, r_done;
  logic             w_ready_nxt, w_serial_out_nxt, w_serial_valid_nxt, w_done_nxt;

  logic w_accept, w_last_bit, w_gap_done, w_rpt_zero;

  assign w_accept   = load && r_ready;
  assign w_last_bit = (r_bit_cnt == '0);
  assign w_gap_done = (r_gap_cnt == '0);
  assign w_rpt_zero = (r_rpt_cnt == '0);

  // State register; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = SEND;
      SEND: begin
        if (w_last_bit) begin
          if (w_rpt_zero)   w_state_nxt = IDLE;
          else if (HAS_GAP) w_state_nxt = GAP;
          else              w_state_nxt = SEND;
        end
      end
      GAP:  if (w_gap_done) w_state_nxt = SEND;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    w_shift_nxt        = r_shift;
    w_pat_nxt          = r_pat;
    w_bit_cnt_nxt      = r_bit_cnt;
    w_rpt_cnt_nxt      = r_rpt_cnt;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_serial_out_nxt   = 1'b0;
    w_serial_valid_nxt = 1'b0;
    w_done_nxt         = 1'b0;
    w_ready_nxt        = (w_state_nxt == IDLE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_pat_nxt          = patternIn;
          w_shift_nxt        = {patternIn[WIDTH-2:0], 1'b0};
          w_rpt_cnt_nxt      = repeat_n;
          w_bit_cnt_nxt      = BC_TOP;
          w_serial_out_nxt   = patternIn[WIDTH-1];
          w_serial_valid_nxt = 1'b1;
        end
      end
      SEND: begin
        if (!w_last_bit) begin
          w_serial_out_nxt   = r_shift[WIDTH-1];
          w_serial_valid_nxt = 1'b1;
          w_shift_nxt        = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt      = r_bit_cnt - 1'b1;
        end else if (w_rpt_zero) begin
          w_done_nxt = 1'b1;
        end else if (HAS_GAP) begin
          w_gap_cnt_nxt = GAP_LOAD;
        end else begin
          // Back-to-back repetition: next pattern's MSB follows immediately.
          w_serial_out_nxt   = r_pat[WIDTH-1];
          w_serial_valid_nxt = 1'b1;
          w_shift_nxt        = {r_pat[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt      = BC_TOP;
          w_rpt_cnt_nxt      = r_rpt_cnt - 1'b1;
        end
      end
      GAP: begin
        if (w_gap_done) begin
          w_serial_out_nxt   = r_pat[WIDTH-1];
          w_serial_valid_nxt = 1'b1;
          w_shift_nxt        = {r_pat[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt      = BC_TOP;
          w_rpt_cnt_nxt      = r_rpt_cnt - 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift        <= '0;
      r_pat          <= '0;
      r_bit_cnt      <= '0;
      r_rpt_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_ready        <= 1'b1;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_shift        <= w_shift_nxt;
      r_pat          <= w_pat_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_rpt_cnt      <= w_rpt_cnt_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_ready        <= w_ready_nxt;
      r_serial_out   <= w_serial_out_nxt;
      r_serial_valid <= w_serial_valid_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign ready        = r_ready;
  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: two instances (no gap, 2-cycle gap) share stimulus.
// A queue-based model expands each accepted transfer into its per-cycle
// output sequence; a compare process checks every cycle after reset.
module tb_pattern_tx;
  import pattern_pkg::*;

  localparam int W = 5;
  localparam int R = 4;
  localparam logic [3:0] IDLE_OUT = 4'b1000; // {ready, valid, out, done}

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         load = 1'b0;
  logic [W-1:0] patternIn = '0;
  logic [R-1:0] repeat_n = '0;

  logic ready0, out0, valid0, done0;
  logic ready2, out2, valid2, done2;
  tx_state_t dbg0, dbg2;

  pattern_tx #(.WIDTH(W), .RPT_W(R), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .patternIn(patternIn),
    .repeat_n(repeat_n), .ready(ready0), .serial_out(out0),
    .serial_valid(valid0), .done(done0), .o_dbg_state(dbg0)
  );

  pattern_tx #(.WIDTH(W), .RPT_W(R), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .load(load), .patternIn(patternIn),
    .repeat_n(repeat_n), .ready(ready2), .serial_out(out2),
    .serial_valid(valid2), .done(done2), .o_dbg_state(dbg2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: front entry = expected outputs of the current cycle.
  logic [3:0] exp0_q[$];
  logic [3:0] exp2_q[$];
  logic [3:0] seq_q[$];
  bit model_on = 0;

  // A transfer is (rpt+1) copies of the pattern MSB-first, gap idle cycles
  // between copies, then one done cycle with ready back up.
  task automatic build_seq(input logic [W-1:0] pat, input int rpt, input int gap);
    seq_q.delete();
    for (int r = 0; r <= rpt; r++) begin
      for (int b = W - 1; b >= 0; b--) seq_q.push_back({1'b0, 1'b1, pat[b], 1'b0});
      if (r < rpt) for (int g = 0; g < gap; g++) seq_q.push_back(4'b0000);
    end
    seq_q.push_back(4'b1001);
  endtask

  always @(posedge clk) begin
    logic [3:0] cur;
    if (!reset_n) begin
      exp0_q.delete();
      exp2_q.delete();
      model_on = 1;
    end else if (model_on) begin
      cur = (exp0_q.size() > 0) ? exp0_q.pop_front() : IDLE_OUT;
      if (load && cur[3]) begin
        build_seq(patternIn, int'(repeat_n), 0);
        foreach (seq_q[i]) exp0_q.push_back(seq_q[i]);
      end
      cur = (exp2_q.size() > 0) ? exp2_q.pop_front() : IDLE_OUT;
      if (load && cur[3]) begin
        build_seq(patternIn, int'(repeat_n), 2);
        foreach (seq_q[i]) exp2_q.push_back(seq_q[i]);
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("gap0_outputs", {28'd0, ready0, valid0, out0, done0},
            {28'd0, (exp0_q.size() > 0) ? exp0_q[0] : IDLE_OUT});
      check("gap2_outputs", {28'd0, ready2, valid2, out2, done2},
            {28'd0, (exp2_q.size() > 0) ? exp2_q[0] : IDLE_OUT});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [W-1:0] p, input logic [R-1:0] rn);
    @(negedge clk);
    load = 1'b1;
    patternIn = p;
    repeat_n = rn;
  endtask

  logic [4:0]  bits, vld;
  logic [5:0]  rdy;
  logic [19:0] vv, dd;
  logic [11:0] dn;
  tx_state_t   st;

  initial begin
    // Reset
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    check("reset_outputs", {28'd0, ready0, valid0, out0, done0}, 32'h8);
    check("reset_state", 32'(dbg0), 32'(IDLE));
    idle(2);

    // Single pattern 11011, no repeat
    start(5'b11011, 4'd0);
    @(negedge clk); load = 1'b0;
    bits = '0; vld = '0;
    for (int c = 1; c <= 5; c++) begin
      bits = {bits[3:0], out0};
      vld  = {vld[3:0], valid0};
      if (c < 5) @(negedge clk);
    end
    @(negedge clk);
    check("t1_bits", 32'(bits), 32'h1B);
    check("t1_valid", 32'(vld), 32'h1F);
    check("t1_done_ready", {30'd0, done0, ready0}, 32'h3);
    idle(3);

    // Repeats with a 2-cycle gap on dut2
    start(5'b10010, 4'd2);
    @(negedge clk); load = 1'b0;
    vv = '0; dd = '0; st = IDLE;
    for (int c = 1; c <= 20; c++) begin
      vv = {vv[18:0], valid2};
      dd = {dd[18:0], done2};
      if (c == 6) st = dbg2;
      if (c < 20) @(negedge clk);
    end
    check("t3_valid_mask", 32'(vv), 32'(20'b11111001111100111110));
    check("t3_done_mask", 32'(dd), 32'h1);
    check("t3_gap_state", 32'(st), 32'(GAP));
    idle(3);

    // Load during a transfer is ignored
    start(5'b11011, 4'd0);
    @(negedge clk); load = 1'b0;
    bits = '0; rdy = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 5) bits = {bits[3:0], out0};
      rdy = {rdy[4:0], ready0};
      if (c == 2) begin load = 1'b1; patternIn = 5'b00000; end
      if (c == 5) load = 1'b0;
      if (c < 6) @(negedge clk);
    end
    check("t4_bits", 32'(bits), 32'h1B);
    check("t4_ready", 32'(rdy), 32'h01);
    idle(3);

    // Load held high: second pattern accepted on the done edge
    start(5'b11111, 4'd0);
    bits = '0; vld = '0; dn = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 7 && c <= 11) begin
        bits = {bits[3:0], out0};
        vld  = {vld[3:0], valid0};
      end
      dn = {dn[10:0], done0};
      if (c == 6) patternIn = 5'b00001;
      if (c == 7) load = 1'b0;
    end
    check("t5_bits", 32'(bits), 32'h01);
    check("t5_valid", 32'(vld), 32'h1F);
    check("t5_done_mask", 32'(dn), 32'(12'b000001000001));
    idle(3);

    // Reset mid-transfer
    start(5'b11011, 4'd3);
    @(negedge clk); load = 1'b0;
    idle(2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_abort", {28'd0, ready0, valid0, out0, done0}, 32'h8);
    check("t6_abort_gap", {28'd0, ready2, valid2, out2, done2}, 32'h8);
    idle(4);
    start(5'b10101, 4'd1);
    @(negedge clk); load = 1'b0;
    idle(25);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset_n   = ($urandom_range(0, 149) != 0);
      load      = ($urandom_range(0, 3) == 0);
      patternIn = W'($urandom);
      repeat_n  = ($urandom_range(0, 4) == 0) ? R'($urandom_range(0, 15))
                                              : R'($urandom_range(0, 2));
    end
    @(negedge clk);
    reset_n = 1'b1;
    load = 1'b0;
    idle(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
